r0_alu_sequencer: RTL

Parametrised successor to the R0 operation multiplexer. Given an opcode and two WIDTH-bit operands, it runs an add, subtract, signed multiply or two's-complement negate and returns the result with status flags.
- Add, subtract and negate complete in one internal cycle; multiply is an iterative radix-2 Booth over WIDTH cycles.
- Operands are captured on a start/busy/done handshake, so the control FSM can issue operations back-to-back.
- Sits between the register file R0 path and the control FSM.

---
 rtl/r0_alu_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/r0_alu_sequencer.sv
// r0_alu_sequencer: start/busy/done ALU for the R0 path.
// ADD/SUB/NEG finish in one EXEC cycle; MUL is a WIDTH-step radix-2 Booth.
// The operand b is parked in the Booth low register so EXEC and MUL share it.
module r0_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam int         CW     = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t           state, state_nx;
    logic [1:0]       op_q, op_nx;
    logic [WIDTH-1:0] a_q, a_nx;
    logic [WIDTH-1:0] hi_q, hi_nx;
    logic [WIDTH-1:0] lo_q, lo_nx;
    logic             qm1_q, qm1_nx;
    logic [CW-1:0]    cnt_q, cnt_nx;
    logic             busy_nx, done_nx, carry_nx, ovf_nx, zero_nx;
    logic [WIDTH-1:0] res_lo_nx, res_hi_nx;

    logic [WIDTH:0]   add_sum, sub_sum, booth_sum;
    logic [WIDTH-1:0] neg_res, min_neg, exec_lo, mul_lo;
    logic             exec_c, exec_v;

    assign min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    assign add_sum = {1'b0, a_q} + {1'b0, lo_q};
    assign sub_sum = {1'b0, a_q} + {1'b0, ~lo_q} + {{WIDTH{1'b0}}, 1'b1};
    assign neg_res = ~a_q + {{(WIDTH-1){1'b0}}, 1'b1};

    // Booth add/sub of a into hi; one guard bit keeps the sign of hi±a exact
    always_comb begin
        booth_sum = {hi_q[WIDTH-1], hi_q};
        case ({lo_q[0], qm1_q})
            2'b01:   booth_sum = {hi_q[WIDTH-1], hi_q} + {a_q[WIDTH-1], a_q};
            2'b10:   booth_sum = {hi_q[WIDTH-1], hi_q} - {a_q[WIDTH-1], a_q};
            default: booth_sum = {hi_q[WIDTH-1], hi_q};
        endcase
    end

    assign mul_lo = {booth_sum[0], lo_q[WIDTH-1:1]};

    // single-cycle result and flags for ADD/SUB/NEG (b lives in lo_q)
    always_comb begin
        exec_lo = neg_res;
        exec_c  = (a_q == '0);
        exec_v  = (a_q == min_neg);
        case (op_q)
            OP_ADD: begin
                exec_lo = add_sum[WIDTH-1:0];
                exec_c  = add_sum[WIDTH];
                exec_v  = (a_q[WIDTH-1] == lo_q[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                exec_lo = sub_sum[WIDTH-1:0];
                exec_c  = sub_sum[WIDTH];
                exec_v  = (a_q[WIDTH-1] != lo_q[WIDTH-1]) &&
                          (sub_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            default: ;
        endcase
    end

    // next-state, datapath and output-register updates
    always_comb begin
        state_nx  = state;
        op_nx     = op_q;
        a_nx      = a_q;
        hi_nx     = hi_q;
        lo_nx     = lo_q;
        qm1_nx    = qm1_q;
        cnt_nx    = cnt_q;
        busy_nx   = busy;
        done_nx   = 1'b0;
        res_lo_nx = result_lo;
        res_hi_nx = result_hi;
        carry_nx  = carry;
        ovf_nx    = overflow;
        zero_nx   = zero;
        case (state)
            IDLE: begin
                if (start) begin
                    op_nx   = op;
                    a_nx    = a;
                    lo_nx   = b;
                    hi_nx   = '0;
                    qm1_nx  = 1'b0;
                    busy_nx = 1'b1;
                    if (op == OP_MUL) begin
                        state_nx = MUL;
                        cnt_nx   = CW'(WIDTH);
                    end else begin
                        state_nx = EXEC;
                    end
                end
            end
            EXEC: begin
                state_nx  = IDLE;
                busy_nx   = 1'b0;
                done_nx   = 1'b1;
                res_lo_nx = exec_lo;
                res_hi_nx = '0;
                carry_nx  = exec_c;
                ovf_nx    = exec_v;
                zero_nx   = (exec_lo == '0);
            end
            MUL: begin
                hi_nx  = booth_sum[WIDTH:1];
                lo_nx  = mul_lo;
                qm1_nx = lo_q[0];
                cnt_nx = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_nx  = IDLE;
                    busy_nx   = 1'b0;
                    done_nx   = 1'b1;
                    res_hi_nx = booth_sum[WIDTH:1];
                    res_lo_nx = mul_lo;
                    carry_nx  = 1'b0;
                    ovf_nx    = 1'b0;
                    zero_nx   = (booth_sum[WIDTH:1] == '0) && (mul_lo == '0);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // state and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            state     <= state_nx;
            op_q      <= op_nx;
            a_q       <= a_nx;
            hi_q      <= hi_nx;
            lo_q      <= lo_nx;
            qm1_q     <= qm1_nx;
            cnt_q     <= cnt_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            result_lo <= res_lo_nx;
            result_hi <= res_hi_nx;
            carry     <= carry_nx;
            overflow  <= ovf_nx;
            zero      <= zero_nx;
        end
    end
endmodule
